// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - iterative AES key-schedule engine with registered round-key read port
//
// Purpose:
//   Expands an NK-word AES cipher key into NW = 4*(NR+1) words, one word per
//   clock, then serves 128-bit round keys from the stored schedule.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle request to expand key_in (ignored while busy)
//   key_in     in   32*NK-bit cipher key, w[0] in the MSBs
//   busy       out  expansion in progress
//   key_valid  out  full schedule stored and readable
//   rd_en      in   round-key read request
//   rd_round   in   round index 0..NR
//   rk_out     out  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered
//   rk_valid   out  rk_out valid this cycle

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_schedule_seq #(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    output logic             busy,
    output logic             key_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [127:0]     rk_out,
    output logic             rk_valid
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            key_valid_q, key_valid_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2:0]      phase_q, phase_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [127:0]    rk_out_q, rk_out_d;
    logic            rk_valid_q, rk_valid_d;

    // Sliding window of the last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1].
    logic [31:0]     win_q [NK];
    logic [31:0]     win_d [NK];
    logic [31:0]     w_q   [NW];

    logic [31:0]     key_words [NK];
    logic            key_load;
    logic            w_we;
    logic [31:0]     t_word;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     temp;
    logic [31:0]     new_word;
    logic            rd_ok;
    logic [IW-1:0]   rd_base;
    logic [127:0]    rk_word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .s (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        for (int k = 0; k < NK; k++) begin
            key_words[k] = key_in[32*(NK-1-k) +: 32];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        key_valid_d = key_valid_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        rcon_d      = rcon_q;
        rk_out_d    = rk_out_q;
        rk_valid_d  = 1'b0;
        win_d       = win_q;
        key_load    = 1'b0;
        w_we        = 1'b0;

        // The S-boxes see RotWord(t) at a phase-0 word and plain t otherwise;
        // their output is only used where the schedule calls for SubWord.
        t_word = win_q[NK-1];
        sub_in = (phase_q == 3'd0) ? {t_word[23:0], t_word[31:24]} : t_word;
        if (phase_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = t_word;
        end
        new_word = win_q[0] ^ temp;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    key_load    = 1'b1;
                    win_d       = key_words;
                    state_d     = S_EXPAND;
                    busy_d      = 1'b1;
                    key_valid_d = 1'b0;
                    idx_d       = IW'(NK);
                    phase_d     = 3'd0;
                    rcon_d      = 8'h01;
                end
            end
            S_EXPAND: begin
                w_we = 1'b1;
                for (int k = 0; k < NK - 1; k++) begin
                    win_d[k] = win_q[k+1];
                end
                win_d[NK-1] = new_word;
                idx_d   = idx_q + 1'b1;
                phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                if (idx_q == IW'(NW - 1)) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    key_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Reads see the pre-edge key_valid and array, so a read coinciding
        // with a restart still returns the old schedule.
        rd_ok   = key_valid_q && (rd_round <= 4'(NR));
        rd_base = rd_ok ? {rd_round, 2'b00} : '0;
        rk_word = {w_q[rd_base], w_q[rd_base + 6'd1],
                   w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        if (rd_en) begin
            rk_valid_d = 1'b1;
            rk_out_d   = rd_ok ? rk_word : 128'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            idx_q       <= '0;
            phase_q     <= 3'd0;
            rcon_q      <= 8'h01;
            rk_out_q    <= 128'h0;
            rk_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            rcon_q      <= rcon_d;
            rk_out_q    <= rk_out_d;
            rk_valid_q  <= rk_valid_d;
        end
    end

    // Schedule storage carries no reset; it is unreadable until key_valid.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (key_load) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= key_words[k];
            end
        end else if (w_we) begin
            w_q[idx_q] <= new_word;
        end
    end

    assign busy      = busy_q;
    assign key_valid = key_valid_q;
    assign rk_out    = rk_out_q;
    assign rk_valid  = rk_valid_q;
endmodule

// File: tb/tb_key_schedule_seq.sv
// tb/tb_key_schedule_seq.sv - self-checking bench for key_schedule_seq at NK=4/6/8
module tb_key_schedule_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic         busy4, kv4, rkv4;
    logic         busy6, kv6, rkv6;
    logic         busy8, kv8, rkv8;
    logic [127:0] rk4, rk6, rk8;

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] sbox_tab [0:255];

    always #5 clk = ~clk;

    key_schedule_seq #(.NK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key4), .busy(busy4),
        .key_valid(kv4), .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk4), .rk_valid(rkv4)
    );
    key_schedule_seq #(.NK(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key6), .busy(busy6),
        .key_valid(kv6), .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk6), .rk_valid(rkv6)
    );
    key_schedule_seq #(.NK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key8), .busy(busy8),
        .key_valid(kv8), .rd_en(rd_en), .rd_round(rd_round), .rk_out(rk8), .rk_valid(rkv8)
    );

    typedef struct {
        int           nk;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;
    vec_t vt [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] get_rk(input int nk);
        case (nk)
            4: return rk4;
            6: return rk6;
            default: return rk8;
        endcase
    endfunction
    function automatic logic get_kv(input int nk);
        case (nk)
            4: return kv4;
            6: return kv6;
            default: return kv8;
        endcase
    endfunction
    function automatic logic get_busy(input int nk);
        case (nk)
            4: return busy4;
            6: return busy6;
            default: return busy8;
        endcase
    endfunction
    function automatic logic get_rkv(input int nk);
        case (nk)
            4: return rkv4;
            6: return rkv6;
            default: return rkv8;
        endcase
    endfunction
    function automatic logic [255:0] get_key(input int nk);
        case (nk)
            4: return {128'h0, key4};
            6: return {64'h0, key6};
            default: return key8;
        endcase
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from the generator-3 walk: p runs over powers of 3, q over powers
    // of 1/3, so q = p^-1 at every step; the affine map then gives S(p).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        for (int k = 0; k < 255; k++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_tab[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < j; k++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        return rc;
    endfunction

    // Whole expansion straight from the FIPS-197 recurrence; key is right-aligned.
    function automatic logic [127:0] ref_rk(input int nk, input logic [255:0] key, input int r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        int nw;
        nw = 4 * (nk + 7);
        if (r > nk + 6) return 128'h0;
        for (int k = 0; k < nk; k++) w[k] = key[32*(nk-1-k) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic rand_keys();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        key8 = k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        key6 = k[191:0];
        key4 = k[255:128];
    endtask

    // Cycle c = edges after the start edge; key_valid must rise at exactly 3*NK+28.
    task automatic watch(input bit inject, input string tag);
        for (int c = 1; c <= 52; c++) begin
            start    = inject && (c == 10);
            rd_en    = inject && (c == 5);
            rd_round = 4'd1;
            if (inject && c == 10) begin
                key4 = ~key4;
                key6 = ~key6;
                key8 = ~key8;
            end
            tick();
            for (int n = 4; n <= 8; n += 2) begin
                int lat;
                lat = 3 * n + 28;
                chk($sformatf("%s key_valid nk%0d c%0d", tag, n, c), 128'(get_kv(n)), 128'(c >= lat));
                chk($sformatf("%s busy nk%0d c%0d", tag, n, c), 128'(get_busy(n)), 128'(c < lat));
                if (inject && c == 5) begin
                    chk($sformatf("%s busy_read rk_valid nk%0d", tag, n), 128'(get_rkv(n)), 128'(1'b1));
                    chk($sformatf("%s busy_read rk_out nk%0d", tag, n), get_rk(n), 128'h0);
                end
                if (inject && c == 6) begin
                    chk($sformatf("%s idle rk_valid nk%0d", tag, n), 128'(get_rkv(n)), 128'(1'b0));
                    chk($sformatf("%s hold rk_out nk%0d", tag, n), get_rk(n), 128'h0);
                end
            end
        end
        start = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 16; r++) begin
            rd_en    = 1'b1;
            rd_round = 4'(r);
            tick();
            for (int n = 4; n <= 8; n += 2) begin
                chk($sformatf("%s rk nk%0d r%0d", tag, n, r), get_rk(n), ref_rk(n, get_key(n), r));
                chk($sformatf("%s rk_valid nk%0d r%0d", tag, n, r), 128'(get_rkv(n)), 128'(1'b1));
            end
        end
        rd_en = 1'b0;
        tick();
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("%s rk_valid_low nk%0d", tag, n), 128'(get_rkv(n)), 128'(1'b0));
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] old [3];
        build_sbox();
        vt[0]  = '{4, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vt[1]  = '{4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[2]  = '{4, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vt[3]  = '{4, 4'd15, 128'h0};
        vt[4]  = '{6, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vt[5]  = '{6, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vt[6]  = '{6, 4'd13, 128'h0};
        vt[7]  = '{8, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        vt[8]  = '{8, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        vt[9]  = '{8, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        vt[10] = '{8, 4'd15, 128'h0};

        rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; rd_round = 4'd0;
        key4 = '0; key6 = '0; key8 = '0;
        repeat (3) tick();
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("reset busy nk%0d", n), 128'(get_busy(n)), 128'(1'b0));
            chk($sformatf("reset key_valid nk%0d", n), 128'(get_kv(n)), 128'(1'b0));
            chk($sformatf("reset rk_valid nk%0d", n), 128'(get_rkv(n)), 128'(1'b0));
            chk($sformatf("reset rk_out nk%0d", n), get_rk(n), 128'h0);
        end
        rst_n = 1'b1;
        tick();

        // Known-answer keys, with a busy read and an ignored second start inside.
        key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        start_pulse();
        watch(1'b1, "kat");
        for (int i = 0; i < 11; i++) begin
            rd_en    = 1'b1;
            rd_round = vt[i].rnd;
            tick();
            chk($sformatf("vec%0d rk nk%0d r%0d", i, vt[i].nk, vt[i].rnd), get_rk(vt[i].nk), vt[i].exp);
            chk($sformatf("vec%0d rk_valid", i), 128'(get_rkv(vt[i].nk)), 128'(1'b1));
        end
        rd_en = 1'b0;
        tick();

        for (int it = 0; it < 3; it++) begin
            rand_keys();
            start_pulse();
            watch(1'b0, $sformatf("rand%0d", it));
            read_all($sformatf("rand%0d", it));
        end

        // Restart from DONE with a read of round 10 on the same edge.
        for (int n = 4; n <= 8; n += 2) old[(n-4)/2] = ref_rk(n, get_key(n), 10);
        rand_keys();
        start = 1'b1; rd_en = 1'b1; rd_round = 4'd10;
        tick();
        start = 1'b0; rd_en = 1'b0;
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("restart old_r10 nk%0d", n), get_rk(n), old[(n-4)/2]);
            chk($sformatf("restart key_valid nk%0d", n), 128'(get_kv(n)), 128'(1'b0));
            chk($sformatf("restart busy nk%0d", n), 128'(get_busy(n)), 128'(1'b1));
        end
        watch(1'b0, "restart");
        read_all("restart");

        // Restart again, then pull reset low at cycle 20 of the expansion.
        for (int n = 4; n <= 8; n += 2) old[(n-4)/2] = ref_rk(n, get_key(n), 0);
        rand_keys();
        start = 1'b1; rd_en = 1'b1; rd_round = 4'd0;
        tick();
        start = 1'b0; rd_en = 1'b0;
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("prereset rk_out nk%0d", n), get_rk(n), old[(n-4)/2]);
        end
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("async busy nk%0d", n), 128'(get_busy(n)), 128'(1'b0));
            chk($sformatf("async key_valid nk%0d", n), 128'(get_kv(n)), 128'(1'b0));
            chk($sformatf("async rk_out nk%0d", n), get_rk(n), 128'h0);
            chk($sformatf("async rk_valid nk%0d", n), 128'(get_rkv(n)), 128'(1'b0));
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        for (int n = 4; n <= 8; n += 2) begin
            chk($sformatf("postreset busy nk%0d", n), 128'(get_busy(n)), 128'(1'b0));
            chk($sformatf("postreset key_valid nk%0d", n), 128'(get_kv(n)), 128'(1'b0));
        end
        rand_keys();
        start_pulse();
        watch(1'b0, "fresh");
        read_all("fresh");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
